scroll_sequencer: RTL

Controller for the 4-digit scrolling message display. It owns the scroll position and a run/stop/step/reverse command interface, paced by a programmable prescaler. It time-shares one external 16-entry nibble lookup (`convert`) across the four digit positions. It scans the digits onto a multiplexed active-low 7-segment display.

---
 rtl/scroll_pkg.sv | 37 +++
 rtl/hex7seg.sv | 14 +
 rtl/scroll_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared definitions for the scrolling message display controller.
// Holds the command op codes, the sequencer FSM state encoding and the
// active-low hex to 7-segment table ({g,f,e,d,c,b,a}, 0 = segment lit).
package scroll_pkg;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_REV  = 2'b11;

    typedef enum logic [1:0] {
        ST_STOPPED   = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_STOP_PEND = 2'd2
    } seq_state_t;

    // Entry [n] is the active-low glyph for hex digit n.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: 4-bit hex digit to active-low 7-segment pattern.
// Ports:
//   digit  in  4  hex value
//   seg    out 7  {g,f,e,d,c,b,a}, active-low
module hex7seg
    import scroll_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = HEX7_TABLE[digit];

endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: scroll position / command controller and 4-digit scanner
// for the scrolling message display. The nibble lookup is external and is
// shared across the four digits by addressing it with pos + sel.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/ready/op   command handshake (STOP, RUN, STEP, REVERSE)
//   conv_in / conv_out   external lookup address / data (combinational)
//   an, seg              active-low digit enables and segments
//   pos, running, dir    scroll status
module scroll_sequencer
    import scroll_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    output logic [3:0] conv_in,
    input  logic [3:0] conv_out,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [3:0] pos,
    output logic       running,
    output logic       dir
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    seq_state_t    state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] scan_cnt_q;
    logic [1:0]    sel_q;
    logic [3:0]    digit_q;
    logic [3:0]    an_q;
    logic [6:0]    glyph;
    logic          accept;
    logic          tick;
    logic [3:0]    pos_step;

    assign cmd_ready = (state_q != ST_STOP_PEND);
    assign running   = (state_q != ST_STOPPED);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = running && (tick_cnt_q == TW'(TICK_DIV - 1));
    // The step always uses the registered dir, so a REVERSE on a tick edge
    // only affects later steps.
    assign pos_step  = pos_q + (dir_q ? 4'hF : 4'h1);

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_STOPPED;
            pos_q      <= 4'd0;
            dir_q      <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Next state: command decode and step pacing
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        tick_cnt_d = tick_cnt_q;
        case (state_q)
            ST_STOPPED: begin
                tick_cnt_d = '0;
                if (accept) begin
                    case (cmd_op)
                        OP_RUN:  state_d = ST_RUNNING;
                        OP_STEP: pos_d   = pos_step;
                        OP_REV:  dir_d   = ~dir_q;
                        default: ;
                    endcase
                end
            end
            ST_RUNNING: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (tick) begin
                    pos_d = pos_step;
                end
                if (accept) begin
                    case (cmd_op)
                        // A STOP landing on a tick has already completed its step.
                        OP_STOP: state_d = tick ? ST_STOPPED : ST_STOP_PEND;
                        OP_REV:  dir_d   = ~dir_q;
                        default: ;
                    endcase
                end
            end
            ST_STOP_PEND: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (tick) begin
                    pos_d   = pos_step;
                    state_d = ST_STOPPED;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // Digit scan and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            sel_q      <= 2'd0;
            digit_q    <= 4'd0;
            an_q       <= 4'b1111;
        end else begin
            if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                sel_q      <= sel_q + 2'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + SW'(1);
            end
            digit_q <= conv_out;
            an_q    <= ~(4'b1000 >> sel_q);
        end
    end

    hex7seg u_hex7seg (
        .digit (digit_q),
        .seg   (glyph)
    );

    assign conv_in = pos_q + {2'b00, sel_q};
    assign an      = an_q;
    // All digits disabled only straight out of reset; keep segments dark then.
    assign seg     = (an_q == 4'b1111) ? 7'h7F : glyph;
    assign pos     = pos_q;
    assign dir     = dir_q;

endmodule
